// File: rtl/exc_sched.sv
// exc_sched: picks the highest-priority exception or interrupt at commit, updates CP0 and redirects fetch.
// Define EXC_INT_SYNC_EN to pass hw_int through a SYNC_STAGES-deep synchroniser before use.
module exc_sched #(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic        commit_bd,
  input  logic        commit_eret,
  input  logic        if_adel,
  input  logic        id_ri,
  input  logic        id_sys,
  input  logic        id_bp,
  input  logic        ex_ov,
  input  logic        mem_adel,
  input  logic        mem_ades,
  input  logic [31:0] mem_addr,
  input  logic [5:0]  hw_int,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic [7:0]  status_im,
  input  logic [1:0]  cause_ip_sw,
  input  logic [31:0] epc_in,
  output logic [5:0]  int_pending,
  output logic        exp_en,
  output logic        exp_badvaddr_en,
  output logic [31:0] exp_badvaddr,
  output logic        exp_bd,
  output logic [4:0]  exp_code,
  output logic [31:0] exp_epc,
  output logic        exl_clr,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  typedef enum logic {IDLE = 1'b0, REDIR = 1'b1} state_t;

  state_t      state, state_d;
  logic        int_req, cause_hit, bva_sel;
  logic [4:0]  cause_code;
  logic [31:0] cause_bva;
  logic        exp_en_d, exp_badvaddr_en_d, exp_bd_d, exl_clr_d;
  logic [4:0]  exp_code_d;
  logic [31:0] exp_badvaddr_d, exp_epc_d, redirect_pc_d;

  if (SYNC_STAGES < 1) begin : g_bad_sync_stages
  end

`ifdef EXC_INT_SYNC_EN
  logic [5:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= hw_int;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign int_pending = sync_q[SYNC_STAGES-1];
`else
  // Already synchronous; masked during reset so every output reads 0 there.
  assign int_pending = rst ? hw_int : 6'd0;
`endif

  always_comb begin
    int_req    = status_ie & ~status_exl & (|({int_pending, cause_ip_sw} & status_im));
    cause_hit  = 1'b1;
    cause_code = 5'd0;
    bva_sel    = 1'b0;
    cause_bva  = 32'd0;
    if (int_req) begin
      cause_code = 5'd0;
    end else if (if_adel) begin
      cause_code = 5'd4;
      bva_sel    = 1'b1;
      cause_bva  = commit_pc;
    end else if (id_ri) begin
      cause_code = 5'd10;
    end else if (ex_ov) begin
      cause_code = 5'd12;
    end else if (id_sys) begin
      cause_code = 5'd8;
    end else if (id_bp) begin
      cause_code = 5'd9;
    end else if (mem_adel) begin
      cause_code = 5'd4;
      bva_sel    = 1'b1;
      cause_bva  = mem_addr;
    end else if (mem_ades) begin
      cause_code = 5'd5;
      bva_sel    = 1'b1;
      cause_bva  = mem_addr;
    end else begin
      cause_hit  = 1'b0;
    end
  end

  // CP0 fields are one-cycle pulses; only redirect_pc holds across cycles.
  always_comb begin
    state_d           = state;
    exp_en_d          = 1'b0;
    exp_badvaddr_en_d = 1'b0;
    exp_badvaddr_d    = 32'd0;
    exp_bd_d          = 1'b0;
    exp_code_d        = 5'd0;
    exp_epc_d         = 32'd0;
    exl_clr_d         = 1'b0;
    redirect_pc_d     = redirect_pc;
    case (state)
      IDLE: begin
        if (commit_valid) begin
          if (cause_hit) begin
            exp_en_d          = 1'b1;
            exp_code_d        = cause_code;
            exp_bd_d          = commit_bd;
            exp_epc_d         = commit_bd ? commit_pc - 32'd4 : commit_pc;
            exp_badvaddr_en_d = bva_sel;
            exp_badvaddr_d    = cause_bva;
            redirect_pc_d     = EXC_VECTOR;
            state_d           = REDIR;
          end else if (commit_eret) begin
            exl_clr_d     = 1'b1;
            redirect_pc_d = epc_in;
            state_d       = REDIR;
          end
        end
      end
      REDIR: begin
        if (redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      exp_en          <= 1'b0;
      exp_badvaddr_en <= 1'b0;
      exp_badvaddr    <= 32'd0;
      exp_bd          <= 1'b0;
      exp_code        <= 5'd0;
      exp_epc         <= 32'd0;
      exl_clr         <= 1'b0;
      redirect_pc     <= 32'd0;
    end else begin
      state           <= state_d;
      exp_en          <= exp_en_d;
      exp_badvaddr_en <= exp_badvaddr_en_d;
      exp_badvaddr    <= exp_badvaddr_d;
      exp_bd          <= exp_bd_d;
      exp_code        <= exp_code_d;
      exp_epc         <= exp_epc_d;
      exl_clr         <= exl_clr_d;
      redirect_pc     <= redirect_pc_d;
    end
  end

  assign flush          = (state == REDIR);
  assign redirect_valid = (state == REDIR);

endmodule
